pdm_tx: RTL and testbench
=========================

// Module: pdm_tx
// PURPOSE
//  AHB-lite slave (external-slave slot es1) that accepts signed PCM samples in a FIFO.
//  It converts them with a 2nd-order sigma-delta modulator into a 1-bit PDM stream and drives pdm_clk_out.
//  It is the transmit counterpart of the PDM capture path; typical targets are a PDM DAC/speaker or loopback into the capture block.
// PARAMETERS
//  BASE_ADDR   32'h801770B0  register window base (4 words)
//  DW          16            PCM sample width, two's complement
//  FIFO_DEPTH  16            sample FIFO entries, power of 2
//  OSR         64            PDM bits per PCM sample
//  CLKDIV_RST  8'd25         CLKDIV reset value
// PORTS
//  g_hclk_es1     in   1   AHB clock; the only clock in the block
//  hreset         in   1   synchronous reset, active-high
//  hsel_es1       in   1   slave select
//  haddr          in   32  address
//  htrans         in   2   transfer type; only NONSEQ/SEQ (htrans[1]=1) are acted on
//  hwrite         in   1   direction
//  hsize          in   3   ignored; all accesses are treated as 32-bit
//  hwdata         in   32  write data (data phase)
//  hready         in   1   bus ready
//  hrdata_es1     out  32  read data
//  hreadyout_es1  out  1   always 1 (zero wait state)
//  hresp_es1      out  1   always 0 (OKAY)
//  pdm_clk_out    out  1   PDM bit clock
//  pdm_out        out  1   PDM data; changes only on the falling edge of pdm_clk_out
// BEHAVIOUR
//  Reset: every flop clears; CLKDIV=CLKDIV_RST; pdm_clk_out=0, pdm_out=0, hrdata_es1=0, FIFO empty, FSM=IDLE.
//  Bus capture:
//   - Address phase is registered when hsel_es1&hready&htrans[1].
//   - The data phase acts in the next cycle that has hready=1.
//   - Reads return data combinationally from the registered address.
//  Registers (offsets from BASE_ADDR):
//   +0x0 CTRL    RW  [0] EN; [1] FLUSH (write-1, self-clearing; reads 0)
//   +0x4 STATUS  R   [0] busy = FSM==RUN; [1] full; [2] empty; [3] UNDERRUN sticky; [4] OVERFLOW sticky; [12:8] level
//                W1C on [4:3]
//   +0x8 DATA    W   hwdata[DW-1:0] pushed to the FIFO; reads 0
//   +0xC CLKDIV  RW  [7:0] N; an effective N<2 is treated as 2
//   Unmapped offsets: reads 0, writes ignored.
//  FIFO:
//   - Push on a DATA write. If full and no pop in the same cycle, the write is dropped and OVERFLOW is set.
//   - Simultaneous push and pop: both occur; push is accepted even when full.
//   - FLUSH empties the FIFO and clears the modulator state. FLUSH beats a same-cycle push; the pushed data is lost.
//  FSM IDLE/RUN:
//   - IDLE: divider count=0, pdm_clk_out=0, pdm_out=0, integrators=0, cur_sample=0, osr_cnt=OSR-1. FIFO contents are kept.
//   - IDLE->RUN when EN=1. RUN->IDLE when EN=0, taking effect the next cycle; mid-bit state is discarded.
//  Divider (RUN only):
//   - The counter runs 0..N-1; at N-1 it wraps and toggles pdm_clk_out.
//   - Period is 2N hclk cycles; the first rising edge occurs N cycles after entering RUN.
//   - bit_tick = the cycle in which pdm_clk_out toggles 1->0.
//  Modulator step on bit_tick (full scale FS = 2^(DW-1)):
//   - fb = prev_out ? +FS : -FS, where prev_out resets to 0.
//   - acc1 += cur_sample - fb
//   - acc2 += acc1 - fb
//   - Both accumulators are DW+4 bits signed and saturate; they never wrap.
//   - pdm_out <= (acc2_next >= 0), registered, so it is valid through the next rising edge.
//  Sample load on bit_tick with osr_cnt==OSR-1:
//   - The FIFO head is popped into cur_sample for the next OSR steps; osr_cnt wraps to 0. Otherwise osr_cnt increments.
//   - Pop on empty: cur_sample=0 and UNDERRUN is set; the stream continues.
//   - The first step after entering RUN uses cur_sample=0.
//  Reset asserted mid-operation: same as the reset state above, in the same cycle.
// STRUCTURE
//  pdm_tx_pkg: register offsets, STATUS/CTRL bit positions, FSM state encoding, saturation limits.
//  Sub-module pdm_tx_fifo: sync FIFO with push, pop, flush, full, empty, level.
//  The top level holds the AHB register slice, divider, FSM and modulator.
// TESTING
//  - Reset, then read all 4 registers -> CTRL=0, STATUS=0x00000004, DATA=0, CLKDIV=25; hreadyout_es1=1, hresp_es1=0.
//  - CLKDIV=2, EN=1, FIFO empty -> pdm_clk_out period 4 hclk, first rise at cycle 2; UNDERRUN=1 after the first bit_tick.
//  - Push 16x 0x7FFF, CLKDIV=2, EN=1 -> ones density over bits 64..1023 >=99%. Push 16x 0x8000 -> ones density <=1%.
//  - Push 16x 0x0000 -> ones count over 1024 bits = 512+/-4; no UNDERRUN while the FIFO is non-empty.
//  - EN=0, write DATA 17 times -> full=1, level=16, OVERFLOW=1. Then write 1 to STATUS[4] -> OVERFLOW=0. Then FLUSH -> empty=1, level=0.
//  - RUN with level=8, assert hreset for 1 cycle -> next cycle pdm_clk_out=0, pdm_out=0, STATUS=0x00000004, CLKDIV=25.

Source files
------------

// File: rtl/pdm_tx_pkg.sv
// Shared constants for the PDM transmitter: register map, bit positions,
// FSM encoding and accumulator sizing.
package pdm_tx_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DATA   = 2'd2;
  localparam logic [1:0] OFF_CLKDIV = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_UNDER   = 3;
  localparam int ST_OVER    = 4;
  localparam int ST_LVL_LSB = 8;

  localparam logic [7:0] CLKDIV_MIN = 8'd2;

  // Accumulators are DW+ACC_GUARD bits; sums are formed ACC_SUM_EXT bits wider
  // so the saturation compare never sees a wrapped value.
  localparam int ACC_GUARD   = 4;
  localparam int ACC_SUM_EXT = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pdm_tx_fifo.sv
// Synchronous sample FIFO with flush; a pop and a push in the same cycle are
// both honoured, even when full.
module pdm_tx_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [DW-1:0]              i_wdata,
  output logic [DW-1:0]              o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_count;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_count == LW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pdm_tx.sv
// AHB-lite PCM sample sink driving a 2nd-order sigma-delta PDM bit stream.
// Holds the register slice, bit-clock divider, IDLE/RUN FSM and modulator.
module pdm_tx
  import pdm_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h801770B0,
  parameter int          DW         = 16,
  parameter int          FIFO_DEPTH = 16,
  parameter int          OSR        = 64,
  parameter logic [7:0]  CLKDIV_RST = 8'd25
) (
  input  logic        g_hclk_es1,
  input  logic        hreset,
  input  logic        hsel_es1,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata_es1,
  output logic        hreadyout_es1,
  output logic        hresp_es1,
  output logic        pdm_clk_out,
  output logic        pdm_out
);
  localparam int AW = DW + ACC_GUARD;
  localparam int XW = AW + ACC_SUM_EXT;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(OSR);

  localparam logic signed [AW-1:0] ACC_MAX   = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN   = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [XW-1:0] ACC_MAX_X = {{(XW-AW){1'b0}}, ACC_MAX};
  localparam logic signed [XW-1:0] ACC_MIN_X = {{(XW-AW){1'b1}}, ACC_MIN};
  localparam logic signed [XW-1:0] FS_X      = {{(XW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};

  function automatic logic signed [AW-1:0] f_sat(input logic signed [XW-1:0] v);
    if (v > ACC_MAX_X)      f_sat = ACC_MAX;
    else if (v < ACC_MIN_X) f_sat = ACC_MIN;
    else                    f_sat = v[AW-1:0];
  endfunction

  // ---------------- AHB register slice ----------------
  logic       r_dvld, r_dwr, r_dhit;
  logic [1:0] r_doff;
  logic       r_en, r_underrun, r_overflow;
  logic [7:0] r_clkdiv;
  logic       w_wr, w_rd;
  logic       w_wr_ctrl, w_wr_status, w_wr_clkdiv;
  logic       w_push, w_pop, w_flush;
  logic       w_under_set, w_over_set;
  logic [31:0] w_rdata;
  logic       w_unused;

  logic [DW-1:0] w_fifo_rdata;
  logic          w_fifo_full, w_fifo_empty;
  logic [LW-1:0] w_fifo_level;

  assign w_unused = ^{hsize, haddr[1:0], hwdata[31:DW]};

  always_ff @(posedge g_hclk_es1) begin
    if (hreset) begin
      r_dvld <= 1'b0;
      r_dwr  <= 1'b0;
      r_dhit <= 1'b0;
      r_doff <= '0;
    end else if (hready) begin
      r_dvld <= hsel_es1 & htrans[1];
      r_dwr  <= hwrite;
      r_dhit <= (haddr[31:4] == BASE_ADDR[31:4]);
      r_doff <= haddr[3:2];
    end
  end

  assign w_wr        = r_dvld & r_dwr & r_dhit & hready;
  assign w_rd        = r_dvld & ~r_dwr & r_dhit;
  assign w_wr_ctrl   = w_wr & (r_doff == OFF_CTRL);
  assign w_wr_status = w_wr & (r_doff == OFF_STATUS);
  assign w_wr_clkdiv = w_wr & (r_doff == OFF_CLKDIV);
  assign w_push      = w_wr & (r_doff == OFF_DATA);
  assign w_flush     = w_wr_ctrl & hwdata[CTRL_FLUSH];

  // ---------------- FSM ----------------
  state_t r_state, w_state_nxt;
  logic   w_run;

  always_ff @(posedge g_hclk_es1) begin
    if (hreset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_en)  w_state_nxt = S_RUN;
      S_RUN:   if (!r_en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run = (r_state == S_RUN);

  // ---------------- divider + modulator ----------------
  logic [7:0]           r_div_cnt, w_n;
  logic                 r_pdm_clk, r_pdm_out, r_prev;
  logic signed [AW-1:0] r_acc1, r_acc2, w_acc1_nxt, w_acc2_nxt;
  logic signed [DW-1:0] r_cur;
  logic [OW-1:0]        r_osr_cnt;
  logic                 w_wrap, w_bit_tick, w_load;
  logic signed [XW-1:0] w_fb, w_sum1, w_sum2;

  assign w_n        = (r_clkdiv < CLKDIV_MIN) ? CLKDIV_MIN : r_clkdiv;
  // >= rather than == so a CLKDIV shrink mid-run cannot strand the counter
  assign w_wrap     = (r_div_cnt >= w_n - 8'd1);
  assign w_bit_tick = w_run & w_wrap & r_pdm_clk;
  assign w_load     = w_bit_tick & (r_osr_cnt == OW'(OSR - 1));
  assign w_pop      = w_load & ~w_flush;

  assign w_fb       = r_prev ? FS_X : -FS_X;
  assign w_sum1     = {{(XW-AW){r_acc1[AW-1]}}, r_acc1} + {{(XW-DW){r_cur[DW-1]}}, r_cur} - w_fb;
  assign w_acc1_nxt = f_sat(w_sum1);
  assign w_sum2     = {{(XW-AW){r_acc2[AW-1]}}, r_acc2} + {{(XW-AW){w_acc1_nxt[AW-1]}}, w_acc1_nxt} - w_fb;
  assign w_acc2_nxt = f_sat(w_sum2);

  always_ff @(posedge g_hclk_es1) begin
    if (hreset || !w_run) begin
      r_div_cnt <= '0;
      r_pdm_clk <= 1'b0;
      r_pdm_out <= 1'b0;
      r_prev    <= 1'b0;
      r_acc1    <= '0;
      r_acc2    <= '0;
      r_cur     <= '0;
      r_osr_cnt <= OW'(OSR - 1);
    end else begin
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_pdm_clk <= ~r_pdm_clk;
      end else begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end
      // Flush restarts the loop filter but leaves pdm_out alone so the data
      // line still only moves on a falling bit-clock edge.
      if (w_flush) begin
        r_prev    <= 1'b0;
        r_acc1    <= '0;
        r_acc2    <= '0;
        r_cur     <= '0;
        r_osr_cnt <= OW'(OSR - 1);
      end else if (w_bit_tick) begin
        r_acc1    <= w_acc1_nxt;
        r_acc2    <= w_acc2_nxt;
        r_prev    <= ~w_acc2_nxt[AW-1];
        r_pdm_out <= ~w_acc2_nxt[AW-1];
        if (w_load) begin
          r_cur     <= w_fifo_empty ? '0 : w_fifo_rdata;
          r_osr_cnt <= '0;
        end else begin
          r_osr_cnt <= r_osr_cnt + OW'(1);
        end
      end
    end
  end

  // ---------------- control / status registers ----------------
  assign w_under_set = w_pop & w_fifo_empty;
  assign w_over_set  = w_push & w_fifo_full & ~w_pop & ~w_flush;

  always_ff @(posedge g_hclk_es1) begin
    if (hreset) begin
      r_en       <= 1'b0;
      r_clkdiv   <= CLKDIV_RST;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ctrl)   r_en     <= hwdata[CTRL_EN];
      if (w_wr_clkdiv) r_clkdiv <= hwdata[7:0];
      if (w_wr_status && hwdata[ST_UNDER]) r_underrun <= 1'b0;
      if (w_under_set)                     r_underrun <= 1'b1;
      if (w_wr_status && hwdata[ST_OVER])  r_overflow <= 1'b0;
      if (w_over_set)                      r_overflow <= 1'b1;
    end
  end

  pdm_tx_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (g_hclk_es1),
    .i_rst   (hreset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (hwdata[DW-1:0]),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (r_doff)
        OFF_CTRL:   w_rdata[CTRL_EN] = r_en;
        OFF_STATUS: begin
          w_rdata[ST_BUSY]            = w_run;
          w_rdata[ST_FULL]            = w_fifo_full;
          w_rdata[ST_EMPTY]           = w_fifo_empty;
          w_rdata[ST_UNDER]           = r_underrun;
          w_rdata[ST_OVER]            = r_overflow;
          w_rdata[ST_LVL_LSB +: LW]   = w_fifo_level;
        end
        OFF_CLKDIV: w_rdata[7:0] = r_clkdiv;
        default:    w_rdata = '0;
      endcase
    end
  end

  assign hrdata_es1    = w_rdata;
  assign hreadyout_es1 = 1'b1;
  assign hresp_es1     = 1'b0;
  assign pdm_clk_out   = r_pdm_clk;
  assign pdm_out       = r_pdm_out;

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx: register map, divider timing, FIFO flags and
// bit-exact PDM stream against an arithmetic sigma-delta reference.
module tb_pdm_tx;
  localparam logic [31:0] BASE = 32'h801770B0;
  localparam int OSR  = 64;
  localparam int FS   = 32768;
  localparam int AMAX = 524287;
  localparam int AMIN = -524288;

  logic        g_hclk_es1 = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel_es1 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;
  logic        hready = 1'b1;
  logic [31:0] hrdata_es1;
  logic        hreadyout_es1, hresp_es1, pdm_clk_out, pdm_out;

  pdm_tx dut (
    .g_hclk_es1(g_hclk_es1), .hreset(hreset), .hsel_es1(hsel_es1), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hrdata_es1(hrdata_es1), .hreadyout_es1(hreadyout_es1), .hresp_es1(hresp_es1),
    .pdm_clk_out(pdm_clk_out), .pdm_out(pdm_out)
  );

  always #5 g_hclk_es1 = ~g_hclk_es1;

  int errs = 0;
  int checks = 0;

  logic [15:0] smp [16];
  bit          cap [2048];
  bit          exp_bits [2048];
  int          ncap;
  bit          prev_clk;

  int m_a1, m_a2, m_cur;
  bit m_prev, m_under;
  int m_q[$];

  task automatic ahb_write(input logic [3:0] off, input logic [31:0] d);
    @(negedge g_hclk_es1);
    hsel_es1 = 1'b1; haddr = BASE | {28'h0, off}; htrans = 2'b10; hwrite = 1'b1;
    @(negedge g_hclk_es1);
    hsel_es1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    @(negedge g_hclk_es1);
  endtask

  task automatic ahb_read(input logic [3:0] off, output logic [31:0] d);
    @(negedge g_hclk_es1);
    hsel_es1 = 1'b1; haddr = BASE | {28'h0, off}; htrans = 2'b10; hwrite = 1'b0;
    @(negedge g_hclk_es1);
    hsel_es1 = 1'b0; htrans = 2'b00;
    d = hrdata_es1;
  endtask

  task automatic chk_reg(input string nm, input logic [3:0] off, input logic [31:0] want);
    logic [31:0] got;
    ahb_read(off, got);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic int sat(input longint v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return int'(v);
  endfunction

  // One modulator step k: uses the held sample, then reloads every OSR steps.
  function automatic bit m_step(input int k);
    int fb;
    fb = m_prev ? FS : -FS;
    m_a1 = sat(longint'(m_a1) + m_cur - fb);
    m_a2 = sat(longint'(m_a2) + m_a1 - fb);
    m_prev = (m_a2 >= 0);
    if (k % OSR == 0) begin
      if (m_q.size() > 0) m_cur = m_q.pop_front();
      else begin m_cur = 0; m_under = 1'b1; end
    end
    return m_prev;
  endfunction

  task automatic collect(input int target);
    int guard = 0;
    while (ncap < target && guard < 20000) begin
      @(negedge g_hclk_es1);
      guard++;
      if (prev_clk && !pdm_clk_out) begin
        cap[ncap] = pdm_out;
        ncap++;
      end
      prev_clk = pdm_clk_out;
    end
  endtask

  // Load smp[] into FIFO and model, start at the given CLKDIV, gather nbits.
  task automatic play(input int div, input int nbits);
    m_a1 = 0; m_a2 = 0; m_cur = 0; m_prev = 1'b0; m_under = 1'b0;
    m_q.delete();
    for (int i = 0; i < 16; i++) begin
      ahb_write(4'h8, {16'h0, smp[i]});
      m_q.push_back(int'($signed(smp[i])));
    end
    for (int k = 0; k < 2048; k++) exp_bits[k] = m_step(k);
    ahb_write(4'hC, div);
    ncap = 0; prev_clk = 1'b0;
    ahb_write(4'h0, 32'h1);
    collect(nbits);
  endtask

  task automatic check_stream(input string nm, input int nbits);
    int mism = 0, first = -1;
    for (int k = 0; k < ncap && k < nbits; k++)
      if (cap[k] !== exp_bits[k]) begin
        mism++;
        if (first < 0) first = k;
      end
    checks++;
    if (ncap != nbits || mism != 0) begin
      errs++;
      $display("FAIL %s: got %0d bits with %0d wrong (first at %0d) want %0d bits exact",
               nm, ncap, mism, first, nbits);
    end
  endtask

  function automatic int ones(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) n += int'(cap[k]);
    return n;
  endfunction

  task automatic stop_run();
    ahb_write(4'h0, 32'h0);
    ahb_write(4'h0, 32'h2);
    ahb_write(4'h4, 32'h18);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge g_hclk_es1);
    hreset = 1'b0;
    checks++;
    if (hreadyout_es1 !== 1'b1 || hresp_es1 !== 1'b0 || pdm_clk_out !== 1'b0 ||
        pdm_out !== 1'b0 || hrdata_es1 !== 32'h0) begin
      errs++;
      $display("FAIL reset_pins: got rdy=%b resp=%b clk=%b out=%b rd=%h want 1 0 0 0 0",
               hreadyout_es1, hresp_es1, pdm_clk_out, pdm_out, hrdata_es1);
    end
    chk_reg("rst_ctrl",   4'h0, 32'h0);
    chk_reg("rst_status", 4'h4, 32'h4);
    chk_reg("rst_data",   4'h8, 32'h0);
    chk_reg("rst_clkdiv", 4'hC, 32'd25);
  endtask

  // Divider timing for one CLKDIV value; effective N is max(div,2).
  task automatic test_clk(input int div);
    int n = (div < 2) ? 2 : div;
    int cnt;
    ahb_write(4'hC, div);
    ahb_write(4'h0, 32'h1);
    // RUN is entered one cycle after EN registers; first rise N cycles later.
    cnt = 0;
    do begin @(negedge g_hclk_es1); cnt++; end while (!pdm_clk_out && cnt < 600);
    checks++;
    if (cnt != n + 1) begin
      errs++; $display("FAIL clk_first_rise div=%0d: got %0d want %0d", div, cnt, n + 1);
    end
    cnt = 0;
    do begin @(negedge g_hclk_es1); cnt++; end while (pdm_clk_out && cnt < 600);
    checks++;
    if (cnt != n) begin
      errs++; $display("FAIL clk_high div=%0d: got %0d want %0d", div, cnt, n);
    end
    cnt = 0;
    do begin @(negedge g_hclk_es1); cnt++; end while (!pdm_clk_out && cnt < 600);
    checks++;
    if (cnt != n) begin
      errs++; $display("FAIL clk_low div=%0d: got %0d want %0d", div, cnt, n);
    end
    chk_reg("underrun_after_tick", 4'h4, 32'h0000000D);
    stop_run();
    chk_reg("status_after_stop", 4'h4, 32'h4);
  endtask

  task automatic test_full_scale();
    int n1;
    for (int i = 0; i < 16; i++) smp[i] = 16'h7FFF;
    play(2, 1024);
    check_stream("stream_pos_fs", 1024);
    n1 = ones(64, 1023);
    checks++;
    if (n1 < 951) begin errs++; $display("FAIL density_pos: got %0d want >=951", n1); end
    stop_run();
    for (int i = 0; i < 16; i++) smp[i] = 16'h8000;
    play(2, 1024);
    check_stream("stream_neg_fs", 1024);
    n1 = ones(64, 1023);
    checks++;
    if (n1 > 9) begin errs++; $display("FAIL density_neg: got %0d want <=9", n1); end
    stop_run();
  endtask

  task automatic test_zero();
    logic [31:0] st;
    int n1;
    for (int i = 0; i < 16; i++) smp[i] = 16'h0000;
    play(2, 1000);
    ahb_read(4'h4, st);
    checks++;
    if (st[3] !== 1'b0) begin errs++; $display("FAIL zero_no_underrun: got %b want 0", st[3]); end
    collect(1024);
    check_stream("stream_zero", 1024);
    n1 = ones(0, 1023);
    checks++;
    if (n1 < 508 || n1 > 516) begin errs++; $display("FAIL density_zero: got %0d want 508..516", n1); end
    stop_run();
  endtask

  task automatic test_random();
    logic [31:0] st;
    int div;
    for (int r = 0; r < 2; r++) begin
      div = $urandom_range(2, 4);
      for (int i = 0; i < 16; i++) smp[i] = 16'($urandom);
      play(div, 1100);
      check_stream("stream_random", 1100);
      ahb_read(4'h4, st);
      checks++;
      if (st[3] !== m_under) begin
        errs++; $display("FAIL random_underrun: got %b want %b", st[3], m_under);
      end
      stop_run();
    end
  endtask

  task automatic test_overflow();
    int n = $urandom_range(1, 15);
    for (int i = 0; i < n; i++) ahb_write(4'h8, $urandom);
    chk_reg("level_random", 4'h4, 32'(n) << 8);
    ahb_write(4'h0, 32'h2);
    chk_reg("flush_random", 4'h4, 32'h4);
    for (int i = 0; i < 17; i++) ahb_write(4'h8, 32'(i));
    chk_reg("overflow_set", 4'h4, 32'h00001012);
    ahb_write(4'h4, 32'h10);
    chk_reg("overflow_w1c", 4'h4, 32'h00001002);
    ahb_write(4'h0, 32'h2);
    chk_reg("flush_empty", 4'h4, 32'h4);
  endtask

  task automatic test_reset_midrun();
    int cnt = 0;
    for (int i = 0; i < 8; i++) ahb_write(4'h8, $urandom);
    ahb_write(4'hC, 32'd6);
    ahb_write(4'h0, 32'h1);
    while (!pdm_clk_out && cnt < 200) begin @(negedge g_hclk_es1); cnt++; end
    checks++;
    if (!pdm_clk_out) begin errs++; $display("FAIL midrun_clk: got 0 want 1 before reset"); end
    hreset = 1'b1;
    @(negedge g_hclk_es1);
    hreset = 1'b0;
    checks++;
    if (pdm_clk_out !== 1'b0 || pdm_out !== 1'b0) begin
      errs++; $display("FAIL midrun_reset_pins: got clk=%b out=%b want 0 0", pdm_clk_out, pdm_out);
    end
    chk_reg("midrun_status", 4'h4, 32'h4);
    chk_reg("midrun_clkdiv", 4'hC, 32'd25);
    chk_reg("midrun_ctrl",   4'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_clk(2);
    test_clk(int'($urandom_range(0, 1)));
    test_clk(int'($urandom_range(3, 5)));
    test_zero();
    test_full_scale();
    test_random();
    test_overflow();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
